// File: rtl/mem_io_bus_pkg.sv
// Shared definitions for the MEM-stage data bus: address map, MMIO register
// offsets, RAM geometry and the value returned by reads of unmapped space.
package mem_io_bus_pkg;

    // RAM region: byte addresses 0x0000_0000 .. 0x0000_0FFF
    localparam int unsigned RAM_DEPTH = 1024;
    localparam int unsigned RAM_AW    = 10;
    localparam logic [31:0] RAM_LIMIT = 32'h0000_1000;

    // MMIO region: 0x0000_7F00 .. 0x0000_7F1F, eight word registers
    localparam logic [31:0] MMIO_BASE = 32'h0000_7F00;

    localparam logic [4:0] OFF_LED        = 5'h00;
    localparam logic [4:0] OFF_SW         = 5'h04;
    localparam logic [4:0] OFF_IN_STATUS  = 5'h08;
    localparam logic [4:0] OFF_IN_DATA    = 5'h0C;
    localparam logic [4:0] OFF_CYCLE      = 5'h10;
    localparam logic [4:0] OFF_OUT_DATA   = 5'h14;
    localparam logic [4:0] OFF_OUT_STATUS = 5'h18;
    localparam logic [4:0] OFF_RSVD       = 5'h1C;

    localparam logic [31:0] UNMAPPED_RD = 32'h0000_0000;

    // Register index as seen on a[4:2]
    typedef enum logic [2:0] {
        REG_LED        = OFF_LED[4:2],
        REG_SW         = OFF_SW[4:2],
        REG_IN_STATUS  = OFF_IN_STATUS[4:2],
        REG_IN_DATA    = OFF_IN_DATA[4:2],
        REG_CYCLE      = OFF_CYCLE[4:2],
        REG_OUT_DATA   = OFF_OUT_DATA[4:2],
        REG_OUT_STATUS = OFF_OUT_STATUS[4:2],
        REG_RSVD       = OFF_RSVD[4:2]
    } mmio_reg_e;

endpackage

// File: rtl/dm_ram.sv
// Data memory: RAM_DEPTH x 32, one synchronous write port, two asynchronous
// read ports (CPU and debug). Contents are never reset.
// Ports: clk, we/a/d (write + CPU read address), spo (CPU read data),
//        dpra (debug read address), dpo (debug read data).
module dm_ram
    import mem_io_bus_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [RAM_AW-1:0] a,
    input  logic [31:0]       d,
    output logic [31:0]       spo,
    input  logic [RAM_AW-1:0] dpra,
    output logic [31:0]       dpo
);

    logic [31:0] mem [RAM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[a] <= d;
    end

    assign spo = mem[a];
    assign dpo = mem[dpra];

endmodule

// File: rtl/mem_io_bus.sv
// MEM-stage bus: decodes the byte address into RAM / MMIO / unmapped space,
// holds the MMIO registers (LED, switches, input strobe, cycle counter,
// output handshake) and the input synchronizers.
// Ports: cpu_clk, cpu_rstn (async, active-high); a/d/dwe/dre MEM access;
//        spo load data; dpra/dpo debug RAM read; sw/btn raw inputs;
//        led, out_data/out_valid/out_ready display output handshake.
module mem_io_bus
    import mem_io_bus_pkg::*;
(
    input  logic        cpu_clk,
    input  logic        cpu_rstn,
    input  logic [31:0] a,
    input  logic [31:0] d,
    input  logic        dwe,
    input  logic        dre,
    output logic [31:0] spo,
    input  logic [31:0] dpra,
    output logic [31:0] dpo,
    input  logic [15:0] sw,
    input  logic        btn,
    output logic [15:0] led,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    logic        in_ram, in_mmio;
    mmio_reg_e   reg_idx;
    logic [31:0] ram_spo;
    logic [15:0] sw_s1, sw_s2;
    logic        btn_s1, btn_s2, btn_d, btn_edge;
    logic        in_valid;
    logic [15:0] in_data;
    logic [31:0] cycle;
    logic        wr_led, wr_cycle, wr_out, rd_in_data;
    logic        unused_bits;

    assign unused_bits = ^{a[1:0], dpra[31:12], dpra[1:0]};

    assign in_ram  = (a < RAM_LIMIT);
    assign in_mmio = (a[31:5] == MMIO_BASE[31:5]);
    assign reg_idx = mmio_reg_e'(a[4:2]);

    assign wr_led     = dwe && in_mmio && (reg_idx == REG_LED);
    assign wr_cycle   = dwe && in_mmio && (reg_idx == REG_CYCLE);
    assign wr_out     = dwe && in_mmio && (reg_idx == REG_OUT_DATA);
    assign rd_in_data = dre && in_mmio && (reg_idx == REG_IN_DATA);

    dm_ram u_dm_ram (
        .clk  (cpu_clk),
        .we   (dwe && in_ram),
        .a    (a[RAM_AW+1:2]),
        .d    (d),
        .spo  (ram_spo),
        .dpra (dpra[RAM_AW+1:2]),
        .dpo  (dpo)
    );

    // Two-flop synchronizers; btn_d delays the synchronized button so a
    // rising edge is seen for exactly one cycle.
    always_ff @(posedge cpu_clk or posedge cpu_rstn) begin
        if (cpu_rstn) begin
            sw_s1  <= '0;
            sw_s2  <= '0;
            btn_s1 <= 1'b0;
            btn_s2 <= 1'b0;
            btn_d  <= 1'b0;
        end else begin
            sw_s1  <= sw;
            sw_s2  <= sw_s1;
            btn_s1 <= btn;
            btn_s2 <= btn_s1;
            btn_d  <= btn_s2;
        end
    end

    assign btn_edge = btn_s2 && !btn_d;

    // A new button edge takes priority over the clear from an IN_DATA read.
    always_ff @(posedge cpu_clk or posedge cpu_rstn) begin
        if (cpu_rstn) begin
            in_valid <= 1'b0;
            in_data  <= '0;
        end else if (btn_edge) begin
            in_valid <= 1'b1;
            in_data  <= sw_s2;
        end else if (rd_in_data) begin
            in_valid <= 1'b0;
        end
    end

    always_ff @(posedge cpu_clk or posedge cpu_rstn) begin
        if (cpu_rstn)      cycle <= '0;
        else if (wr_cycle) cycle <= d;
        else               cycle <= cycle + 32'd1;
    end

    always_ff @(posedge cpu_clk or posedge cpu_rstn) begin
        if (cpu_rstn)    led <= '0;
        else if (wr_led) led <= d[15:0];
    end

    // A write outranks a same-cycle transfer, so fresh data is never lost.
    always_ff @(posedge cpu_clk or posedge cpu_rstn) begin
        if (cpu_rstn) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (wr_out) begin
            out_data  <= d;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_comb begin
        spo = UNMAPPED_RD;
        if (in_ram) begin
            spo = ram_spo;
        end else if (in_mmio) begin
            unique case (reg_idx)
                REG_LED:        spo = {16'h0000, led};
                REG_SW:         spo = {16'h0000, sw_s2};
                REG_IN_STATUS:  spo = {31'd0, in_valid};
                REG_IN_DATA:    spo = {16'h0000, in_data};
                REG_CYCLE:      spo = cycle;
                REG_OUT_DATA:   spo = out_data;
                REG_OUT_STATUS: spo = {31'd0, out_valid};
                REG_RSVD:       spo = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_io_bus.sv
// Directed bench for mem_io_bus: RAM access and decode, input strobe path,
// cycle counter wrap, output handshake, LED register and async reset.
module tb_mem_io_bus;

    logic        cpu_clk;
    logic        cpu_rstn;
    logic [31:0] a, d, dpra, spo, dpo, out_data;
    logic        dwe, dre, btn, out_valid, out_ready;
    logic [15:0] sw, led;

    int vectors    = 0;
    int miscompares = 0;

    mem_io_bus dut (
        .cpu_clk   (cpu_clk),
        .cpu_rstn  (cpu_rstn),
        .a         (a),
        .d         (d),
        .dwe       (dwe),
        .dre       (dre),
        .spo       (spo),
        .dpra      (dpra),
        .dpo       (dpo),
        .sw        (sw),
        .btn       (btn),
        .led       (led),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are then changed 1 time unit after the edge.
    task automatic step();
        @(posedge cpu_clk);
        #1;
    endtask

    initial begin
        cpu_rstn = 1'b1;
        a = '0; d = '0; dpra = '0; dwe = 0; dre = 0;
        sw = '0; btn = 0; out_ready = 0;
        #3;
        chk("rst_led", {16'h0, led}, 32'h0);
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_out_data", out_data, 32'h0);
        step(); step();
        cpu_rstn = 1'b0;
        a = 32'h7F10; #1;
        chk("cycle_first", spo, 32'h0);
        step();
        chk("cycle_second", spo, 32'h1);

        // RAM write / read, region boundaries
        a = 32'h0; d = 32'h1111_0000; dwe = 1; step();
        a = 32'h10; d = 32'h1234_5678; step();
        dwe = 0; a = 32'h10; dpra = 32'h10; #1;
        chk("ram_spo", spo, 32'h1234_5678);
        chk("ram_dpo", dpo, 32'h1234_5678);
        a = 32'h2000; d = 32'hDEAD_BEEF; dwe = 1; step();
        a = 32'h1000; d = 32'hBAAD_F00D; step();
        dwe = 0; a = 32'h2000; #1;
        chk("unmapped_rd", spo, 32'h0);
        a = 32'h1000; #1;
        chk("ram_limit_rd", spo, 32'h0);
        a = 32'h13; dpra = 32'h0; #1;
        chk("ram_low_bits", spo, 32'h1234_5678);
        chk("ram_word0_intact", dpo, 32'h1111_0000);
        a = 32'h7F1C; #1;
        chk("rsvd_rd", spo, 32'h0);

        // Input strobe path
        sw = 16'h00A5; btn = 1; step(); step(); step();
        a = 32'h7F08; #1;
        chk("in_status_set", spo, 32'h1);
        a = 32'h7F0C; #1;
        chk("in_data", spo, 32'h0000_00A5);
        a = 32'h7F04; #1;
        chk("sw_sync", spo, 32'h0000_00A5);
        btn = 0; step(); step(); step();
        a = 32'h7F08; #1;
        chk("in_status_held", spo, 32'h1);
        a = 32'h7F0C; dre = 1; step();
        dre = 0; a = 32'h7F08; #1;
        chk("in_status_clr", spo, 32'h0);
        sw = 16'h003C; btn = 1; step(); step(); step();
        btn = 0; step(); step(); step();
        sw = 16'h005A; btn = 1; step(); step();
        a = 32'h7F0C; dre = 1; #1;
        chk("in_data_before_edge", spo, 32'h0000_003C);
        step();
        dre = 0; a = 32'h7F08; #1;
        chk("in_status_set_wins", spo, 32'h1);
        a = 32'h7F0C; #1;
        chk("in_data_set_wins", spo, 32'h0000_005A);
        btn = 0;

        // Cycle counter load and wrap
        a = 32'h7F10; d = 32'hFFFF_FFFE; dwe = 1; step();
        dwe = 0; #1;
        chk("cycle_load", spo, 32'hFFFF_FFFE);
        step();
        chk("cycle_max", spo, 32'hFFFF_FFFF);
        step();
        chk("cycle_wrap", spo, 32'h0);

        // Output handshake
        out_ready = 0;
        a = 32'h7F14; d = 32'h0000_CAFE; dwe = 1; step();
        dwe = 0;
        for (int i = 0; i < 5; i++) begin
            chk("out_hold_valid", {31'h0, out_valid}, 32'h1);
            chk("out_hold_data", out_data, 32'h0000_CAFE);
            step();
        end
        a = 32'h7F18; #1;
        chk("out_status_rd", spo, 32'h1);
        a = 32'h7F14; #1;
        chk("out_data_rd", spo, 32'h0000_CAFE);
        out_ready = 1; step();
        out_ready = 0; #1;
        chk("out_xfer_valid", {31'h0, out_valid}, 32'h0);
        chk("out_xfer_data", out_data, 32'h0000_CAFE);
        d = 32'h0000_BEEF; dwe = 1; step();
        d = 32'h0000_1234; out_ready = 1; step();
        dwe = 0; out_ready = 0; #1;
        chk("out_write_wins_valid", {31'h0, out_valid}, 32'h1);
        chk("out_write_wins_data", out_data, 32'h0000_1234);
        a = 32'h7F04; d = 32'hFFFF_FFFF; dwe = 1; step();
        dwe = 0; #1;
        chk("ro_write_ignored", spo, 32'h0000_005A);

        // LED and asynchronous reset between edges
        a = 32'h7F00; d = 32'hFFFF_00FF; dwe = 1; step();
        dwe = 0; #1;
        chk("led_out", {16'h0, led}, 32'h0000_00FF);
        chk("led_rd", spo, 32'h0000_00FF);
        #1;
        cpu_rstn = 1'b1;
        a = 32'h7F08; dpra = 32'h10; #1;
        chk("arst_led", {16'h0, led}, 32'h0);
        chk("arst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("arst_out_data", out_data, 32'h0);
        chk("arst_in_valid", spo, 32'h0);
        a = 32'h7F10; #1;
        chk("arst_cycle", spo, 32'h0);
        a = 32'h7F0C; #1;
        chk("arst_in_data", spo, 32'h0);
        a = 32'h10; #1;
        chk("arst_ram_spo", spo, 32'h1234_5678);
        chk("arst_ram_dpo", dpo, 32'h1234_5678);
        step();
        cpu_rstn = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
